// File: rtl/audio_attenuation_matrix_pkg.sv
// Shared types, constants and the attenuation-to-gain mapping for the CD-i audio path.
package audio_attenuation_matrix_pkg;

  typedef logic [7:0] atten_t;

  localparam atten_t ATTEN_MUTE = 8'd128;

  // Matrix element slots: LL, LR, RL, RR.
  localparam logic [1:0] IdxLl = 2'd0;
  localparam logic [1:0] IdxLr = 2'd1;
  localparam logic [1:0] IdxRl = 2'd2;
  localparam logic [1:0] IdxRr = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StMulLl,
    StMulRl,
    StMulLr,
    StMulRr,
    StOut
  } state_e;

  // 0.5 dB steps, Q1.15 unsigned gain; index 128 and above is mute.
  // Only ever evaluated at elaboration, so the real arithmetic never reaches the netlist.
  function automatic logic [15:0] atten_gain(input int unsigned n);
    real g;
    if (n >= 128) return 16'd0;
    g = 32767.0 * (10.0 ** (-real'(n) / 40.0));
    return 16'($rtoi(g + 0.5));
  endfunction

endpackage

// File: rtl/audio_gain_lut.sv
// Combinational 129 x 16 ROM mapping an attenuation step to its linear gain.
module audio_gain_lut
  import audio_attenuation_matrix_pkg::*;
(
  input  logic [7:0]  idx_i,
  output logic [15:0] gain_o
);

  logic [15:0] rom [129];

  for (genvar i = 0; i < 129; i++) begin : g_rom
    localparam logic [15:0] Gain = atten_gain(i);
    assign rom[i] = Gain;
  end

  always_comb begin
    gain_o = '0;
    if (idx_i <= ATTEN_MUTE) gain_o = rom[idx_i];
  end

endmodule

// File: rtl/audio_attenuation_matrix.sv
// CD-i 2x2 stereo attenuation matrix with per-sample ramping and one shared multiplier.
module audio_attenuation_matrix
  import audio_attenuation_matrix_pkg::*;
#(
  parameter bit          RAMP_ENABLE = 1'b1,
  parameter int unsigned GAIN_FRAC   = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sample_strobe_i,
  input  logic [15:0] in_left_i,
  input  logic [15:0] in_right_i,
  input  logic [7:0]  atten_ll_i,
  input  logic [7:0]  atten_lr_i,
  input  logic [7:0]  atten_rl_i,
  input  logic [7:0]  atten_rr_i,
  input  logic        apply_i,
  input  logic        mute_i,
  output logic [15:0] audio_left_o,
  output logic [15:0] audio_right_o,
  output logic        out_strobe_o,
  output logic        ramp_active_o,
  output logic        overrun_o
);

  state_e             state_q, state_d;
  atten_t             atten_in [4];
  atten_t             tgt_q [4], tgt_d [4], cur_q [4], cur_d [4], eff [4];
  logic [15:0]        lut_gain [4], gain_q [4], gain_d [4];
  logic signed [15:0] left_q, left_d, right_q, right_d;
  logic signed [32:0] acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic signed [15:0] mul_a;
  logic [15:0]        mul_b;
  logic signed [32:0] prod;
  logic [15:0]        audio_left_q, audio_left_d, audio_right_q, audio_right_d;
  logic               out_strobe_q, out_strobe_d, overrun_q, overrun_d;

  assign atten_in = '{atten_ll_i, atten_lr_i, atten_rl_i, atten_rr_i};

  for (genvar i = 0; i < 4; i++) begin : g_lut
    audio_gain_lut u_lut (
      .idx_i  (cur_q[i]),
      .gain_o (lut_gain[i])
    );
  end

  function automatic atten_t ramp_step(input atten_t cur, input atten_t tgt);
    if (!RAMP_ENABLE) return tgt;
    if (cur < tgt) return cur + 8'd1;
    if (cur > tgt) return cur - 8'd1;
    return cur;
  endfunction

  function automatic logic [15:0] sat16(input logic signed [32:0] acc);
    logic signed [32:0] sh;
    sh = acc >>> GAIN_FRAC;
    if (sh > 33'sd32767) return 16'h7fff;
    if (sh < -33'sd32768) return 16'h8000;
    return 16'(sh);
  endfunction

  // A coincident apply feeds the same-cycle ramp step, hence tgt_d rather than tgt_q.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      tgt_d[i] = tgt_q[i];
      if (apply_i) tgt_d[i] = (atten_in[i] > ATTEN_MUTE) ? ATTEN_MUTE : atten_in[i];
      eff[i] = mute_i ? ATTEN_MUTE : tgt_d[i];
    end
  end

  always_comb begin
    ramp_active_o = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (cur_q[i] != (mute_i ? ATTEN_MUTE : tgt_q[i])) ramp_active_o = 1'b1;
    end
  end

  always_comb begin
    mul_a = left_q;
    mul_b = gain_q[IdxLl];
    unique case (state_q)
      StMulRl: begin mul_a = right_q; mul_b = gain_q[IdxRl]; end
      StMulLr: mul_b = gain_q[IdxLr];
      StMulRr: begin mul_a = right_q; mul_b = gain_q[IdxRr]; end
      default: ;
    endcase
  end

  // Signed sample times unsigned gain; both widened to the accumulator width.
  assign prod = $signed({{17{mul_a[15]}}, mul_a}) * $signed({17'd0, mul_b});

  always_comb begin
    state_d       = state_q;
    cur_d         = cur_q;
    gain_d        = gain_q;
    left_d        = left_q;
    right_d       = right_q;
    acc_l_d       = acc_l_q;
    acc_r_d       = acc_r_q;
    audio_left_d  = audio_left_q;
    audio_right_d = audio_right_q;
    out_strobe_d  = 1'b0;
    overrun_d     = overrun_q;
    if (sample_strobe_i && (state_q != StIdle)) overrun_d = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (sample_strobe_i) begin
          left_d  = in_left_i;
          right_d = in_right_i;
          gain_d  = lut_gain;
          acc_l_d = '0;
          acc_r_d = '0;
          for (int i = 0; i < 4; i++) cur_d[i] = ramp_step(cur_q[i], eff[i]);
          state_d = StMulLl;
        end
      end
      StMulLl: begin acc_l_d = acc_l_q + prod; state_d = StMulRl; end
      StMulRl: begin acc_l_d = acc_l_q + prod; state_d = StMulLr; end
      StMulLr: begin acc_r_d = acc_r_q + prod; state_d = StMulRr; end
      StMulRr: begin acc_r_d = acc_r_q + prod; state_d = StOut;   end
      StOut: begin
        audio_left_d  = sat16(acc_l_q);
        audio_right_d = sat16(acc_r_q);
        out_strobe_d  = 1'b1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      tgt_q         <= '{8'd0, ATTEN_MUTE, ATTEN_MUTE, 8'd0};
      cur_q         <= '{default: ATTEN_MUTE};
      gain_q        <= '{default: '0};
      left_q        <= '0;
      right_q       <= '0;
      acc_l_q       <= '0;
      acc_r_q       <= '0;
      audio_left_q  <= '0;
      audio_right_q <= '0;
      out_strobe_q  <= 1'b0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      tgt_q         <= tgt_d;
      cur_q         <= cur_d;
      gain_q        <= gain_d;
      left_q        <= left_d;
      right_q       <= right_d;
      acc_l_q       <= acc_l_d;
      acc_r_q       <= acc_r_d;
      audio_left_q  <= audio_left_d;
      audio_right_q <= audio_right_d;
      out_strobe_q  <= out_strobe_d;
      overrun_q     <= overrun_d;
    end
  end

  assign audio_left_o  = audio_left_q;
  assign audio_right_o = audio_right_q;
  assign out_strobe_o  = out_strobe_q;
  assign overrun_o     = overrun_q;

endmodule

// File: tb/tb_audio_attenuation_matrix.sv
// Directed bench for audio_attenuation_matrix: ramping, matrix math, saturation, mute, overrun.
module tb_audio_attenuation_matrix;

  logic        clk = 1'b0;
  logic        reset;
  logic        sample_strobe;
  logic [15:0] in_left, in_right;
  logic [7:0]  atten_ll, atten_lr, atten_rl, atten_rr;
  logic        apply, mute;
  logic [15:0] audio_left, audio_right;
  logic        out_strobe, ramp_active, overrun;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  audio_attenuation_matrix dut (
    .clk             (clk),
    .reset           (reset),
    .sample_strobe_i (sample_strobe),
    .in_left_i       (in_left),
    .in_right_i      (in_right),
    .atten_ll_i      (atten_ll),
    .atten_lr_i      (atten_lr),
    .atten_rl_i      (atten_rl),
    .atten_rr_i      (atten_rr),
    .apply_i         (apply),
    .mute_i          (mute),
    .audio_left_o    (audio_left),
    .audio_right_o   (audio_right),
    .out_strobe_o    (out_strobe),
    .ramp_active_o   (ramp_active),
    .overrun_o       (overrun)
  );

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // One sample; lat = negedges from strobe to out_strobe, -1 on timeout.
  task automatic do_sample(input logic [15:0] l, input logic [15:0] r, output int lat);
    lat = -1;
    @(negedge clk);
    sample_strobe = 1'b1;
    in_left       = l;
    in_right      = r;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      sample_strobe = 1'b0;
      if (out_strobe) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_samples(input int n, input logic [15:0] l, input logic [15:0] r);
    int lat;
    int bad;
    bad = 0;
    for (int i = 0; i < n; i++) begin
      do_sample(l, r, lat);
      if (lat != 6) bad++;
    end
    n_tests++;
    if (bad != 0) begin
      n_fail++;
      $display("FAIL run_samples_latency: %0d of %0d samples off latency, required 0", bad, n);
    end
  endtask

  task automatic set_atten(input logic [7:0] ll, input logic [7:0] lr, input logic [7:0] rl,
                           input logic [7:0] rr);
    @(negedge clk);
    atten_ll = ll;
    atten_lr = lr;
    atten_rl = rl;
    atten_rr = rr;
    apply    = 1'b1;
    @(negedge clk);
    apply = 1'b0;
  endtask

  task automatic test_reset;
    reset         = 1'b1;
    sample_strobe = 1'b0;
    in_left       = '0;
    in_right      = '0;
    atten_ll      = '0;
    atten_lr      = '0;
    atten_rl      = '0;
    atten_rr      = '0;
    apply         = 1'b0;
    mute          = 1'b0;
    repeat (3) @(negedge clk);
    n_tests++;
    if (audio_left !== 16'd0 || audio_right !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_audio: got %0d/%0d, required 0/0",
               $signed(audio_left), $signed(audio_right));
    end
    n_tests++;
    if (out_strobe !== 1'b0 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: out_strobe=%b overrun=%b, required 0/0", out_strobe, overrun);
    end
    n_tests++;
    if (ramp_active !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ramp_active: got %b, required 1", ramp_active);
    end
    reset = 1'b0;
  endtask

  task automatic test_ramp_in;
    run_samples(127, 16'd0, 16'd0);
    n_tests++;
    if (ramp_active !== 1'b1) begin
      n_fail++;
      $display("FAIL ramp_in_127: ramp_active=%b, required 1", ramp_active);
    end
    run_samples(1, 16'd0, 16'd0);
    n_tests++;
    if (ramp_active !== 1'b0) begin
      n_fail++;
      $display("FAIL ramp_in_128: ramp_active=%b, required 0", ramp_active);
    end
  endtask

  task automatic test_latency;
    int lat;
    do_sample(16'd1000, 16'hF830, lat);
    n_tests++;
    if (lat != 6) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles, required 6", lat);
    end
    n_tests++;
    if (audio_left !== 16'd999 || audio_right !== 16'hF830) begin
      n_fail++;
      $display("FAIL unity_matrix: got %0d/%0d, required 999/-2000",
               $signed(audio_left), $signed(audio_right));
    end
    @(negedge clk);
    n_tests++;
    if (out_strobe !== 1'b0 || audio_left !== 16'd999) begin
      n_fail++;
      $display("FAIL strobe_pulse_hold: out_strobe=%b left=%0d, required 0/999",
               out_strobe, $signed(audio_left));
    end
  endtask

  task automatic test_saturation;
    int lat;
    set_atten(8'd0, 8'd0, 8'd0, 8'd0);
    run_samples(128, 16'd0, 16'd0);
    n_tests++;
    if (ramp_active !== 1'b0) begin
      n_fail++;
      $display("FAIL sat_settle: ramp_active=%b, required 0", ramp_active);
    end
    do_sample(16'h7FFF, 16'h7FFF, lat);
    n_tests++;
    if (audio_left !== 16'h7FFF || audio_right !== 16'h7FFF) begin
      n_fail++;
      $display("FAIL sat_pos: got %0d/%0d, required 32767/32767",
               $signed(audio_left), $signed(audio_right));
    end
    do_sample(16'h8000, 16'h8000, lat);
    n_tests++;
    if (audio_left !== 16'h8000 || audio_right !== 16'h8000) begin
      n_fail++;
      $display("FAIL sat_neg: got %0d/%0d, required -32768/-32768",
               $signed(audio_left), $signed(audio_right));
    end
    do_sample(16'd10000, 16'd10000, lat);
    n_tests++;
    if (audio_left !== 16'd19999 || audio_right !== 16'd19999) begin
      n_fail++;
      $display("FAIL full_sum: got %0d/%0d, required 19999/19999",
               $signed(audio_left), $signed(audio_right));
    end
  endtask

  task automatic test_mute;
    int lat;
    @(negedge clk);
    mute = 1'b1;
    #1;
    n_tests++;
    if (ramp_active !== 1'b1) begin
      n_fail++;
      $display("FAIL mute_ramp_start: ramp_active=%b, required 1", ramp_active);
    end
    run_samples(127, 16'd10000, 16'd10000);
    n_tests++;
    if (ramp_active !== 1'b1) begin
      n_fail++;
      $display("FAIL mute_ramp_127: ramp_active=%b, required 1", ramp_active);
    end
    run_samples(1, 16'd10000, 16'd10000);
    n_tests++;
    if (ramp_active !== 1'b0) begin
      n_fail++;
      $display("FAIL mute_ramp_128: ramp_active=%b, required 0", ramp_active);
    end
    do_sample(16'd10000, 16'd10000, lat);
    n_tests++;
    if (audio_left !== 16'd0 || audio_right !== 16'd0) begin
      n_fail++;
      $display("FAIL muted_out: got %0d/%0d, required 0/0",
               $signed(audio_left), $signed(audio_right));
    end
    @(negedge clk);
    mute = 1'b0;
    run_samples(128, 16'd10000, 16'd10000);
    n_tests++;
    if (ramp_active !== 1'b0) begin
      n_fail++;
      $display("FAIL unmute_settle: ramp_active=%b, required 0", ramp_active);
    end
    do_sample(16'd10000, 16'd10000, lat);
    n_tests++;
    if (audio_left !== 16'd19999 || audio_right !== 16'd19999) begin
      n_fail++;
      $display("FAIL unmute_out: got %0d/%0d, required 19999/19999",
               $signed(audio_left), $signed(audio_right));
    end
  endtask

  task automatic test_gain_levels;
    int lat;
    // 20 dB on LL, 40 dB on RR, cross terms muted via out-of-range requests.
    set_atten(8'd40, 8'hFF, 8'h80, 8'd80);
    run_samples(128, 16'd0, 16'd0);
    n_tests++;
    if (ramp_active !== 1'b0) begin
      n_fail++;
      $display("FAIL levels_settle: ramp_active=%b, required 0", ramp_active);
    end
    do_sample(16'd10000, 16'd10000, lat);
    n_tests++;
    if (audio_left !== 16'd1000 || audio_right !== 16'd100) begin
      n_fail++;
      $display("FAIL levels_pos: got %0d/%0d, required 1000/100",
               $signed(audio_left), $signed(audio_right));
    end
    do_sample(16'hD8F0, 16'd0, lat);
    n_tests++;
    if (audio_left !== 16'hFC17 || audio_right !== 16'd0) begin
      n_fail++;
      $display("FAIL levels_floor: got %0d/%0d, required -1001/0",
               $signed(audio_left), $signed(audio_right));
    end
  endtask

  task automatic test_overrun;
    int cnt;
    int lat;
    n_tests++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_clear: got %b, required 0", overrun);
    end
    cnt = 0;
    @(negedge clk);
    sample_strobe = 1'b1;
    in_left       = 16'd1000;
    in_right      = 16'd1000;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      sample_strobe = (k == 2);
      if (out_strobe) cnt++;
    end
    n_tests++;
    if (cnt != 1) begin
      n_fail++;
      $display("FAIL overrun_single_out: got %0d out_strobes, required 1", cnt);
    end
    n_tests++;
    if (overrun !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got %b, required 1", overrun);
    end
    n_tests++;
    if (audio_left !== 16'd100 || audio_right !== 16'd10) begin
      n_fail++;
      $display("FAIL overrun_data: got %0d/%0d, required 100/10",
               $signed(audio_left), $signed(audio_right));
    end
    do_sample(16'd0, 16'd0, lat);
    n_tests++;
    if (overrun !== 1'b1 || lat != 6) begin
      n_fail++;
      $display("FAIL overrun_sticky: overrun=%b lat=%0d, required 1/6", overrun, lat);
    end
  endtask

  task automatic test_reset_mid;
    int cnt;
    int lat;
    do_sample(16'd10000, 16'd10000, lat);
    @(negedge clk);
    sample_strobe = 1'b1;
    in_left       = 16'd10000;
    in_right      = 16'd10000;
    @(negedge clk);
    sample_strobe = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    n_tests++;
    if (out_strobe !== 1'b0 || audio_left !== 16'd0 || audio_right !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_out: strobe=%b out=%0d/%0d, required 0 and 0/0",
               out_strobe, $signed(audio_left), $signed(audio_right));
    end
    n_tests++;
    if (overrun !== 1'b0 || ramp_active !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_flags: overrun=%b ramp_active=%b, required 0/1",
               overrun, ramp_active);
    end
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_strobe) cnt++;
    end
    n_tests++;
    if (cnt != 0) begin
      n_fail++;
      $display("FAIL reset_mid_no_strobe: got %0d out_strobes, required 0", cnt);
    end
    do_sample(16'd10000, 16'd10000, lat);
    n_tests++;
    if (lat != 6 || audio_left !== 16'd0 || audio_right !== 16'd0) begin
      n_fail++;
      $display("FAIL reset_mid_cur_mute: lat=%0d out=%0d/%0d, required 6 and 0/0",
               lat, $signed(audio_left), $signed(audio_right));
    end
  endtask

  initial begin
    test_reset();
    test_ramp_in();
    test_latency();
    test_saturation();
    test_mute();
    test_gain_levels();
    test_overrun();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
